// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package display_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WAIT   = 2'd1,
        SHOW   = 2'd2
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;
    localparam logic [1:0] LIVES_DIGIT = 2'd0;
    localparam logic [1:0] SCORE_DIGIT = 2'd3;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Display bus between the game logic and the scan scheduler.
// Optional LIVES_BLINK_EN adds the lives_low input.
interface display_scan_scheduler_if;
    logic [6:0]  score_cathode;
    logic [6:0]  lives_cathode;
    logic        msg_req;
    logic [27:0] msg_cathodes;
    logic        msg_grant;
    logic        msg_done;
    logic [3:0]  anode;
    logic [6:0]  cathode;
`ifdef LIVES_BLINK_EN
    logic        lives_low;

    modport master (output score_cathode, lives_cathode, msg_req, msg_cathodes, lives_low,
                    input  msg_grant, msg_done, anode, cathode);
    modport slave  (input  score_cathode, lives_cathode, msg_req, msg_cathodes, lives_low,
                    output msg_grant, msg_done, anode, cathode);
`else
    modport master (output score_cathode, lives_cathode, msg_req, msg_cathodes,
                    input  msg_grant, msg_done, anode, cathode);
    modport slave  (input  score_cathode, lives_cathode, msg_req, msg_cathodes,
                    output msg_grant, msg_done, anode, cathode);
`endif
endinterface

// File: rtl/display_scan_scheduler_scan_timer.sv
// Digit slot timer: slot counter, digit index, blanking window and frame markers.
module scan_timer #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] index_o,
    output logic       blank_o,
    output logic       slot_wrap_o,
    output logic       frame_start_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] slot_cnt_q;
    logic [1:0]    index_q;
    logic          first_q;

    assign slot_wrap_o   = (slot_cnt_q == CW'(CLK_DIV - 1));
    assign blank_o       = (32'(slot_cnt_q) < 32'(BLANK_CYCLES));
    // The first cycle out of reset also opens a frame so a fresh scan starts cleanly.
    assign frame_start_o = first_q | (slot_wrap_o & (index_q == 2'd3));
    assign index_o       = index_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            index_q    <= 2'd0;
            first_q    <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (slot_wrap_o) begin
                slot_cnt_q <= '0;
                index_q    <= index_q + 2'd1;
            end else begin
                slot_cnt_q <= slot_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/display_scan_scheduler.sv
// Time-slices the 4-digit display between live score/lives and a one-shot message.
// Optional LIVES_BLINK_EN blinks the lives digit every 64 frames while lives_low is set.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int MSG_FRAMES   = 250
) (
    input  logic                     clk,
    input  logic                     rst_n,
    display_scan_scheduler_if.slave  bus
);
    localparam int FW = (MSG_FRAMES > 1) ? $clog2(MSG_FRAMES) : 1;

    logic [1:0] index;
    logic       blank, slot_wrap, frame_start, frame_wrap;

    scan_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .index_o       (index),
        .blank_o       (blank),
        .slot_wrap_o   (slot_wrap),
        .frame_start_o (frame_start)
    );

    // Real frame boundaries only; the post-reset marker never advances a frame count.
    assign frame_wrap = frame_start & slot_wrap;

    disp_state_e state_q;
    logic        rearm_q;
    logic [FW-1:0] frame_cnt_q;
    logic [27:0] msg_q;
    logic [3:0]  anode_q;
    logic [6:0]  cathode_q;
    logic        grant_q, done_q;
    logic [6:0]  normal_seg, src_seg;

`ifdef LIVES_BLINK_EN
    logic [6:0] blink_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blink_cnt_q <= '0;
        else if (frame_wrap) blink_cnt_q <= blink_cnt_q + 7'd1;
    end
`endif

    always_comb begin
        normal_seg = SEG_BLANK;
        case (index)
            LIVES_DIGIT: normal_seg = bus.lives_cathode;
            SCORE_DIGIT: normal_seg = bus.score_cathode;
            default:     normal_seg = SEG_BLANK;
        endcase
`ifdef LIVES_BLINK_EN
        if (bus.lives_low && blink_cnt_q[6] && (index == LIVES_DIGIT)) normal_seg = SEG_BLANK;
`endif
        src_seg = (state_q == SHOW) ? msg_q[index*7 +: 7] : normal_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NORMAL;
            rearm_q     <= 1'b1;
            frame_cnt_q <= '0;
            msg_q       <= '0;
            anode_q     <= ANODE_OFF;
            cathode_q   <= SEG_BLANK;
            grant_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            grant_q   <= 1'b0;
            done_q    <= 1'b0;
            anode_q   <= blank ? ANODE_OFF : anode_for(index);
            cathode_q <= blank ? SEG_BLANK : src_seg;
            if (!bus.msg_req) rearm_q <= 1'b1;
            case (state_q)
                NORMAL: if (bus.msg_req && rearm_q) state_q <= WAIT;
                WAIT: begin
                    if (!bus.msg_req) begin
                        state_q <= NORMAL;
                    end else if (frame_start) begin
                        msg_q       <= bus.msg_cathodes;
                        grant_q     <= 1'b1;
                        frame_cnt_q <= '0;
                        state_q     <= SHOW;
                    end
                end
                SHOW: begin
                    if (frame_wrap) begin
                        if (frame_cnt_q == FW'(MSG_FRAMES - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= NORMAL;
                            if (bus.msg_req) rearm_q <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= NORMAL;
            endcase
        end
    end

    assign bus.anode     = anode_q;
    assign bus.cathode   = cathode_q;
    assign bus.msg_grant = grant_q;
    assign bus.msg_done  = done_q;
endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
- Owns the shared 4-digit seven-segment display and time-slices it between the live game readouts (score, lives) and a one-shot message requester (e.g. "game over" text).
- Generates its own digit refresh timing from the system clock and inserts anti-ghosting blanking between digits.
- Grants the message requester the whole display for a fixed number of refresh frames through a req/grant/done handshake.

Parameters:
- CLK_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < CLK_DIV.
- MSG_FRAMES, 250, complete frames (4 slots each) a granted message is shown; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- score_cathode  in  7  active-low segment pattern for score, digit 3
- lives_cathode  in  7  active-low segment pattern for lives, digit 0
- msg_req  in  1  level request for message display
- msg_cathodes  in  28  four active-low patterns; [6:0] is digit 0 … [27:21] is digit 3
- msg_grant  out  1  one-cycle pulse when message captured and display handed over
- msg_done  out  1  one-cycle pulse when MSG_FRAMES frames complete
- anode  out  4  active-low digit enables; bit i drives digit i
- cathode  out  7  active-low segments

Behaviour:
- Reset (async assert, sync release): anode=4'b1111, cathode=7'h7F, msg_grant=0, msg_done=0, slot counter=0, digit index=0, state=NORMAL, rearm=1.
- Timing:
  - slot_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - Digit index increments on each wrap, 3 -> 0.
  - frame_start = wrap with index 3->0, plus the first cycle after reset.
- Outputs are registered, so they reflect the current slot_cnt/index one cycle later.
  - While slot_cnt < BLANK_CYCLES: anode=4'b1111, cathode=7'h7F.
  - Otherwise: anode = ~(1<<index), cathode = source pattern.
- Sources in NORMAL:
  - index 0 = lives_cathode.
  - index 3 = score_cathode.
  - index 1,2 = 7'h7F, anode still pulsed.
  - Inputs are sampled live each cycle.
- FSM:
  - NORMAL: if msg_req=1 and rearm=1, go to WAIT.
  - WAIT: at the next frame_start, capture msg_cathodes, pulse msg_grant, clear frame_cnt, go to SHOW. If msg_req drops while in WAIT, return to NORMAL with no grant.
  - SHOW: every digit shows its captured msg pattern. frame_cnt increments at each frame_start. When frame_cnt reaches MSG_FRAMES, on that frame_start pulse msg_done, clear rearm, and go to NORMAL; the new frame shows normal sources. msg_req is ignored in SHOW.
  - rearm: set when msg_req is sampled low. A held msg_req therefore never re-triggers without first deasserting.
- A request arriving on the same cycle as frame_start while in NORMAL: move to WAIT only; the grant comes at the following frame_start, so the latency is deterministic.
- Reset mid-SHOW aborts the message: no msg_done, outputs blank immediately.
- Counter widths are $clog2 of the respective limits. No overflow wrap past MSG_FRAMES.

Optional Feature:
- Macro: LIVES_BLINK_EN.
- Defined:
  - Adds input lives_low (1 bit).
  - When lives_low=1 in NORMAL, digit 0 is forced to 7'h7F on alternate 64-frame periods, i.e. while bit 6 of a free-running frame counter = 1.
  - No effect in SHOW.
  - The frame counter resets to 0.
- Undefined: port absent; digit 0 always shows lives_cathode.

Decomposition:
- Package display_pkg holds:
  - the state enum (NORMAL, WAIT, SHOW);
  - SEG_BLANK = 7'h7F, ANODE_OFF = 4'b1111;
  - digit index constants LIVES_DIGIT=0, SCORE_DIGIT=3.
- Sub-module scan_timer: contains slot_cnt and the digit index; outputs index, blank, slot_wrap and frame_start. The top holds the FSM, capture registers and output registers.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2, MSG_FRAMES=3):
- Reset, score=7'h40, lives=7'h79 -> anode cycles 1110,1101,1011,0111 with each slot 2 cycles 1111 then 6 active. Cathode is 7'h79 in slot 0 and 7'h40 in slot 3; period 32 cycles.
- Assert msg_req mid-frame with msg_cathodes=28'h0A1B2C3 -> msg_grant pulses exactly at the next frame_start. All 4 digits show captured slices for 3 frames (96 cycles). msg_done pulses once, then score/lives resume.
- Hold msg_req high through msg_done -> no second grant until msg_req is low for ≥1 cycle, then re-raised.
- Raise msg_req, drop it before frame_start -> no msg_grant, display stays NORMAL.
- Assert rst_n=0 during SHOW frame 2 -> anode=1111 and cathode=7F asynchronously; no msg_done; after release, NORMAL from digit 0.
- LIVES_BLINK_EN with lives_low=1 -> digit 0 blanked during frames 64-127, shown during frames 0-63 and 128-191.
